eqv_monitor: RTL and testbench

Downstream run-time companion to the dual-output circuit under test. Consumes its two outputs `o1`/`o2`, which must be equal every cycle, and adds a settle window, mismatch counting and a sticky failure state. Used in simulation benches and on-chip debug, alongside the formal `o1 == o2` property.

---
 rtl/eqv_monitor.sv | 178 +++++++++++++++++
 tb/tb_eqv_monitor.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/eqv_monitor.sv
//------------------------------------------------------------------------------
// Module      : eqv_monitor
// Description : Run-time equivalence monitor for a dual-output circuit.
//               Registers the two outputs every cycle, ignores a settle window
//               after start, then counts cycles and mismatches, captures the
//               cycle of the first mismatch and latches a sticky failure once
//               MAX_ERR mismatches have been counted.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
// Ports
//   clk_i          clock, all state on rising edge
//   rst_ni         asynchronous active-low reset
//   start_i        begin a monitoring run (IDLE only)
//   stop_i         end the run, return to IDLE
//   clear_i        synchronous abort, zero counters, go to IDLE
//   o1_i, o2_i     the two outputs that must always match
//   busy_o         high in SETTLE and RUN
//   fail_o         high in FAIL
//   mismatch_o     one-cycle pulse per counted mismatch
//   err_cnt_o      counted mismatches (saturating)
//   cyc_cnt_o      RUN cycles elapsed (saturating)
//   first_err_o    cyc_cnt value at the first counted mismatch
//   first_valid_o  first_err_o holds a captured value
//------------------------------------------------------------------------------
`default_nettype none

module eqv_monitor #(
  parameter int CNT_W   = 16,
  parameter int SETTLE  = 2,
  parameter int MAX_ERR = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             clear_i,
  input  logic             o1_i,
  input  logic             o2_i,
  output logic             busy_o,
  output logic             fail_o,
  output logic             mismatch_o,
  output logic [CNT_W-1:0] err_cnt_o,
  output logic [CNT_W-1:0] cyc_cnt_o,
  output logic [CNT_W-1:0] first_err_o,
  output logic             first_valid_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_RUN    = 2'd2,
    S_FAIL   = 2'd3
  } state_e;

  // Settle down-counter only ever holds values 0 .. SETTLE-1.
  localparam int SET_W       = (SETTLE > 2) ? $clog2(SETTLE) : 1;
  localparam int SETTLE_LOAD = (SETTLE > 0) ? SETTLE - 1 : 0;
  localparam logic [SET_W-1:0] SET_LOAD_C = SET_W'(SETTLE_LOAD);
  localparam logic [CNT_W-1:0] MAX_ERR_C  = CNT_W'(MAX_ERR);

  state_e             state_q, state_d;
  logic               o1_q, o2_q;
  logic [SET_W-1:0]   set_q, set_d;
  logic [CNT_W-1:0]   err_q, err_d;
  logic [CNT_W-1:0]   cyc_q, cyc_d;
  logic [CNT_W-1:0]   first_q, first_d;
  logic               fv_q, fv_d;
  logic               mis_q, mis_d;

  logic               diff;
  logic [CNT_W-1:0]   err_inc;
  logic [CNT_W-1:0]   cyc_inc;

  assign diff    = o1_q ^ o2_q;
  // Saturating increments: hold at all-ones rather than wrap.
  assign err_inc = (&err_q) ? err_q : err_q + 1'b1;
  assign cyc_inc = (&cyc_q) ? cyc_q : cyc_q + 1'b1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      o1_q    <= 1'b0;
      o2_q    <= 1'b0;
      set_q   <= '0;
      err_q   <= '0;
      cyc_q   <= '0;
      first_q <= '0;
      fv_q    <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      o1_q    <= o1_i;
      o2_q    <= o2_i;
      set_q   <= set_d;
      err_q   <= err_d;
      cyc_q   <= cyc_d;
      first_q <= first_d;
      fv_q    <= fv_d;
      mis_q   <= mis_d;
    end
  end

  always_comb begin
    state_d = state_q;
    set_d   = set_q;
    err_d   = err_q;
    cyc_d   = cyc_q;
    first_d = first_q;
    fv_d    = fv_q;
    mis_d   = 1'b0;

    if (clear_i) begin
      state_d = S_IDLE;
      set_d   = '0;
      err_d   = '0;
      cyc_d   = '0;
      first_d = '0;
      fv_d    = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start_i) begin
            err_d   = '0;
            cyc_d   = '0;
            first_d = '0;
            fv_d    = 1'b0;
            set_d   = SET_LOAD_C;
            state_d = (SETTLE == 0) ? S_RUN : S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (stop_i) begin
            state_d = S_IDLE;
          end else if (set_q == '0) begin
            state_d = S_RUN;
          end else begin
            set_d = set_q - 1'b1;
          end
        end
        S_RUN: begin
          cyc_d = cyc_inc;
          if (diff) begin
            mis_d = 1'b1;
            err_d = err_inc;
            if (!fv_q) begin
              first_d = cyc_q;
              fv_d    = 1'b1;
            end
          end
          // A mismatch coinciding with stop is still counted, and reaching
          // the threshold takes precedence over returning to IDLE.
          if (diff && (err_inc == MAX_ERR_C)) begin
            state_d = S_FAIL;
          end else if (stop_i) begin
            state_d = S_IDLE;
          end
        end
        S_FAIL: begin
          state_d = S_FAIL;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  assign busy_o        = (state_q == S_SETTLE) || (state_q == S_RUN);
  assign fail_o        = (state_q == S_FAIL);
  assign mismatch_o    = mis_q;
  assign err_cnt_o     = err_q;
  assign cyc_cnt_o     = cyc_q;
  assign first_err_o   = first_q;
  assign first_valid_o = fv_q;

endmodule

`default_nettype wire

// File: tb/tb_eqv_monitor.sv
//------------------------------------------------------------------------------
// Module      : tb_eqv_monitor
// Description : Directed self-checking bench for eqv_monitor (SETTLE=2,
//               MAX_ERR=4, CNT_W=16).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_eqv_monitor;

  localparam int CNT_W = 16;

  logic             clk_i;
  logic             rst_ni;
  logic             start_i;
  logic             stop_i;
  logic             clear_i;
  logic             o1_i;
  logic             o2_i;
  logic             busy_o;
  logic             fail_o;
  logic             mismatch_o;
  logic [CNT_W-1:0] err_cnt_o;
  logic [CNT_W-1:0] cyc_cnt_o;
  logic [CNT_W-1:0] first_err_o;
  logic             first_valid_o;

  int n_chk;
  int n_err;

  eqv_monitor #(
    .CNT_W   (CNT_W),
    .SETTLE  (2),
    .MAX_ERR (4)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .start_i       (start_i),
    .stop_i        (stop_i),
    .clear_i       (clear_i),
    .o1_i          (o1_i),
    .o2_i          (o2_i),
    .busy_o        (busy_o),
    .fail_o        (fail_o),
    .mismatch_o    (mismatch_o),
    .err_cnt_o     (err_cnt_o),
    .cyc_cnt_o     (cyc_cnt_o),
    .first_err_o   (first_err_o),
    .first_valid_o (first_valid_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Present a sample that is captured at the next edge, then return pins low.
  task automatic inject(input logic b1, input logic b2);
    o1_i = b1;
    o2_i = b2;
    tick();
    o1_i = 1'b0;
    o2_i = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".busy"},  32'(busy_o),        0);
    chk({tag, ".fail"},  32'(fail_o),        0);
    chk({tag, ".mis"},   32'(mismatch_o),    0);
    chk({tag, ".err"},   32'(err_cnt_o),     0);
    chk({tag, ".cyc"},   32'(cyc_cnt_o),     0);
    chk({tag, ".ferr"},  32'(first_err_o),   0);
    chk({tag, ".fval"},  32'(first_valid_o), 0);
  endtask

  initial begin
    n_chk   = 0;
    n_err   = 0;
    rst_ni  = 1'b1;
    start_i = 1'b0;
    stop_i  = 1'b0;
    clear_i = 1'b0;
    o1_i    = 1'b0;
    o2_i    = 1'b0;

    // ---------------- reset ----------------
    #1 rst_ni = 1'b0;
    repeat (3) tick();
    chk_all_zero("reset");
    rst_ni = 1'b1;
    tick();

    // ---------------- equal outputs: 20 RUN cycles then stop ----------------
    start_i = 1'b1;
    tick();                                  // E: into SETTLE
    start_i = 1'b0;
    chk("eq.busy_settle", 32'(busy_o), 1);
    tick();                                  // E+1
    tick();                                  // E+2: into RUN, cyc=0
    chk("eq.cyc_start", 32'(cyc_cnt_o), 0);
    repeat (19) tick();
    chk("eq.cyc19", 32'(cyc_cnt_o), 19);
    stop_i = 1'b1;
    tick();                                  // 20th RUN edge, back to IDLE
    stop_i = 1'b0;
    chk("eq.cyc", 32'(cyc_cnt_o), 20);
    chk("eq.err", 32'(err_cnt_o), 0);
    chk("eq.fval", 32'(first_valid_o), 0);
    chk("eq.busy", 32'(busy_o), 0);
    tick();
    chk("eq.retain", 32'(cyc_cnt_o), 20);

    // ---------------- settle masking ----------------
    o1_i    = 1'b1;
    start_i = 1'b1;
    tick();                                  // E: sample 1 captured (masked)
    start_i = 1'b0;
    chk("mask.cleared", 32'(cyc_cnt_o), 0);
    tick();                                  // E+1: sample 1 masked, sample 2 captured
    o1_i = 1'b0;
    tick();                                  // E+2: sample 2 masked, RUN entered
    chk("mask.mis0", 32'(mismatch_o), 0);
    tick();                                  // E+3: cyc=1
    chk("mask.mis1", 32'(mismatch_o), 0);
    chk("mask.err", 32'(err_cnt_o), 0);

    // ---------------- first-error capture at cyc_cnt=5 ----------------
    repeat (3) tick();                       // E+6: cyc=4
    chk("fe.cyc4", 32'(cyc_cnt_o), 4);
    inject(1'b1, 1'b0);                      // E+7: captured, cyc=5
    chk("fe.no_early", 32'(mismatch_o), 0);
    tick();                                  // E+8: counted
    chk("fe.pulse", 32'(mismatch_o), 1);
    chk("fe.ferr", 32'(first_err_o), 5);
    chk("fe.fval", 32'(first_valid_o), 1);
    chk("fe.err", 32'(err_cnt_o), 1);
    tick();
    chk("fe.pulse_end", 32'(mismatch_o), 0);
    inject(1'b0, 1'b1);
    tick();
    chk("fe.err2", 32'(err_cnt_o), 2);
    chk("fe.ferr_kept", 32'(first_err_o), 5);

    // ---------------- asynchronous reset mid-run ----------------
    #2 rst_ni = 1'b0;
    #1;
    chk_all_zero("areset");
    #2 rst_ni = 1'b1;

    // ---------------- threshold with stop on 4th mismatch ----------------
    start_i = 1'b1;
    tick();                                  // E
    start_i = 1'b0;
    chk("thr.busy", 32'(busy_o), 1);
    tick();
    tick();                                  // E+2: RUN, cyc=0
    inject(1'b1, 1'b1);                      // equal-high sample, cyc=1
    tick();                                  // cyc=2
    chk("thr.eqhigh_mis", 32'(mismatch_o), 0);
    chk("thr.eqhigh_err", 32'(err_cnt_o), 0);
    inject(1'b0, 1'b1);                      // captured, cyc=3
    tick();                                  // counted at cyc pre=3
    chk("thr.err1", 32'(err_cnt_o), 1);
    chk("thr.ferr", 32'(first_err_o), 3);
    tick();
    tick();
    inject(1'b1, 1'b0);
    tick();
    chk("thr.err2", 32'(err_cnt_o), 2);
    inject(1'b1, 1'b0);
    tick();
    chk("thr.err3", 32'(err_cnt_o), 3);
    chk("thr.cyc10", 32'(cyc_cnt_o), 10);
    inject(1'b0, 1'b1);                      // cyc=11
    stop_i = 1'b1;
    tick();                                  // 4th mismatch with stop: FAIL wins
    stop_i = 1'b0;
    chk("thr.fail", 32'(fail_o), 1);
    chk("thr.busy_fall", 32'(busy_o), 0);
    chk("thr.pulse4", 32'(mismatch_o), 1);
    chk("thr.err4", 32'(err_cnt_o), 4);
    chk("thr.cyc12", 32'(cyc_cnt_o), 12);
    chk("thr.ferr3", 32'(first_err_o), 3);

    // FAIL is sticky: diff, stop and start are ignored and counters freeze.
    inject(1'b1, 1'b0);
    tick();
    chk("fail.mis", 32'(mismatch_o), 0);
    chk("fail.err", 32'(err_cnt_o), 4);
    chk("fail.cyc", 32'(cyc_cnt_o), 12);
    stop_i = 1'b1;
    tick();
    stop_i  = 1'b0;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk("fail.sticky", 32'(fail_o), 1);
    chk("fail.nobusy", 32'(busy_o), 0);

    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    chk_all_zero("clear");

    // ---------------- clear + start together in IDLE ----------------
    clear_i = 1'b1;
    start_i = 1'b1;
    tick();
    clear_i = 1'b0;
    start_i = 1'b0;
    chk("cs.idle", 32'(busy_o), 0);

    // ---------------- clear suppresses a pending mismatch ----------------
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk("post.busy", 32'(busy_o), 1);
    tick();
    tick();                                  // RUN
    inject(1'b1, 1'b0);
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    chk("clrmis.mis", 32'(mismatch_o), 0);
    chk("clrmis.err", 32'(err_cnt_o), 0);
    chk("clrmis.busy", 32'(busy_o), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
